// File: rtl/dcache_responder_pkg.sv
// Shared types and helpers for the dcache responder: access sizes, FSM states,
// store-buffer entry layout and geometry helpers.
package dcache_responder_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE  = 2'd0,
        MEM_HALF  = 2'd1,
        MEM_WORD  = 2'd2,
        MEM_DWORD = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DRAIN       = 2'd1,
        ST_REFILL_REQ  = 2'd2,
        ST_REFILL_WAIT = 2'd3
    } dcache_state_t;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 64;
    localparam int OFFSET_W = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        mem_size_t         size;
    } sb_entry_t;

    function automatic int index_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_width(input int num_lines);
        return ADDR_W - OFFSET_W - $clog2(num_lines);
    endfunction

    // Byte lanes touched by an access of the given size at the given line offset.
    function automatic logic [7:0] byte_enable(input mem_size_t size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            MEM_BYTE:  base = 8'h01;
            MEM_HALF:  base = 8'h03;
            MEM_WORD:  base = 8'h0F;
            MEM_DWORD: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/dcache_store_buffer.sv
// Power-of-two FIFO holding stores until they are written through to memory.
module dcache_store_buffer
    import dcache_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  sb_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output sb_entry_t head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = entries[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (do_push) begin
            entries[wr_ptr_reg] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-through dcache responder with a store buffer in front of memory.
// Optional: define DCACHE_MMIO_BYPASS_EN to treat addr[31:28]==4'hF as uncached.
module dcache_responder
    import dcache_responder_pkg::*;
#(
    parameter int NUM_LINES = 64,
    parameter int SB_DEPTH  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        core2dcache_req,
    input  logic [31:0] core2dcache_addr,
    input  logic [63:0] core2dcache_data,
    input  logic        core2dcache_data_we,
    input  mem_size_t   core2dcache_data_size,
    output logic        dcache2core_ready,
    output logic [63:0] dcache2core_data,
    output logic        dcache2core_data_valid,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    output mem_size_t   mem_req_size,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data
);
    localparam int IDX_W = index_width(NUM_LINES);
    localparam int TAG_W = tag_width(NUM_LINES);

    dcache_state_t   state_reg, state_next;
    logic [63:0]     line_mem [NUM_LINES];
    logic [TAG_W-1:0] tag_mem [NUM_LINES];
    logic [NUM_LINES-1:0] valid_bits_reg;
    logic [31:0]     load_addr_reg;
    logic [63:0]     data_reg;
    logic            data_valid_reg;

    logic [IDX_W-1:0] req_idx, load_idx;
    logic [TAG_W-1:0] req_tag, load_tag;
    logic [2:0]       req_off, load_off;
    logic [63:0]      line_rd, wdata_shift, merged_line;
    logic [7:0]       store_be;
    logic             req_mmio, load_mmio, hit, accept, load_go, store_go, refill_done;
    logic [31:0]      refill_addr;
    mem_size_t        refill_size;
    logic             sb_full, sb_empty, sb_pop, drain_active;
    sb_entry_t        sb_head, sb_push_entry;

    assign req_idx  = core2dcache_addr[OFFSET_W +: IDX_W];
    assign req_tag  = core2dcache_addr[31 -: TAG_W];
    assign req_off  = core2dcache_addr[2:0];
    assign load_idx = load_addr_reg[OFFSET_W +: IDX_W];
    assign load_tag = load_addr_reg[31 -: TAG_W];
    assign load_off = load_addr_reg[2:0];

`ifdef DCACHE_MMIO_BYPASS_EN
    mem_size_t load_size_reg;
    always_ff @(posedge clock) begin
        if (reset) load_size_reg <= MEM_BYTE;
        else if (load_go) load_size_reg <= core2dcache_data_size;
    end
    assign req_mmio    = (core2dcache_addr[31:28] == 4'hF);
    assign load_mmio   = (load_addr_reg[31:28] == 4'hF);
    assign refill_addr = load_mmio ? load_addr_reg : {load_addr_reg[31:3], 3'b000};
    assign refill_size = load_mmio ? load_size_reg : MEM_DWORD;
`else
    assign req_mmio    = 1'b0;
    assign load_mmio   = 1'b0;
    assign refill_addr = {load_addr_reg[31:3], 3'b000};
    assign refill_size = MEM_DWORD;
`endif

    assign line_rd     = line_mem[req_idx];
    assign hit         = valid_bits_reg[req_idx] & (tag_mem[req_idx] == req_tag) & ~req_mmio;
    assign accept      = core2dcache_req & dcache2core_ready;
    assign load_go     = accept & ~core2dcache_data_we;
    assign store_go    = accept & core2dcache_data_we;
    assign refill_done = ~reset & (state_reg == ST_REFILL_WAIT) & mem_resp_valid;

    // Store-hit merge: replace only the enabled byte lanes of the resident line.
    assign store_be    = byte_enable(core2dcache_data_size, req_off);
    assign wdata_shift = core2dcache_data << {req_off, 3'b000};
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_merge
            assign merged_line[gi*8 +: 8] = store_be[gi] ? wdata_shift[gi*8 +: 8] : line_rd[gi*8 +: 8];
        end
    endgenerate

    assign sb_push_entry = '{addr: core2dcache_addr, data: core2dcache_data, size: core2dcache_data_size};
    assign sb_pop        = mem_req_valid & mem_req_ready & mem_req_we;

    dcache_store_buffer #(.DEPTH(SB_DEPTH)) u_store_buffer (
        .clock      (clock),
        .reset      (reset),
        .push       (store_go),
        .push_entry (sb_push_entry),
        .pop        (sb_pop),
        .full       (sb_full),
        .empty      (sb_empty),
        .head       (sb_head)
    );

    always_ff @(posedge clock) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:        if (load_go && !hit) state_next = sb_empty ? ST_REFILL_REQ : ST_DRAIN;
            ST_DRAIN:       if (sb_empty) state_next = ST_REFILL_REQ;
            ST_REFILL_REQ:  if (mem_req_ready) state_next = ST_REFILL_WAIT;
            ST_REFILL_WAIT: if (mem_resp_valid) state_next = ST_IDLE;
        endcase
    end

    // Memory port is owned by the refill in REFILL_REQ and by the drain otherwise.
    assign drain_active = ((state_reg == ST_IDLE) || (state_reg == ST_DRAIN)) && !sb_empty;

    always_comb begin
        dcache2core_ready = 1'b0;
        mem_req_valid     = 1'b0;
        mem_req_we        = 1'b0;
        mem_req_addr      = '0;
        mem_req_wdata     = '0;
        mem_req_size      = MEM_BYTE;
        if (!reset) begin
            dcache2core_ready = (state_reg == ST_IDLE) && !sb_full;
            if (state_reg == ST_REFILL_REQ) begin
                mem_req_valid = 1'b1;
                mem_req_addr  = refill_addr;
                mem_req_size  = refill_size;
            end else if (drain_active) begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = sb_head.addr;
                mem_req_wdata = sb_head.data;
                mem_req_size  = sb_head.size;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (refill_done && !load_mmio) begin
            line_mem[load_idx] <= mem_resp_data;
            tag_mem[load_idx]  <= load_tag;
        end else if (store_go && hit) begin
            line_mem[req_idx]  <= merged_line;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_bits_reg <= '0;
            load_addr_reg  <= '0;
            data_reg       <= '0;
            data_valid_reg <= 1'b0;
        end else begin
            data_valid_reg <= 1'b0;
            if (load_go) load_addr_reg <= core2dcache_addr;
            if (load_go && hit) begin
                data_reg       <= line_rd >> {req_off, 3'b000};
                data_valid_reg <= 1'b1;
            end else if (refill_done) begin
                data_reg       <= load_mmio ? mem_resp_data : (mem_resp_data >> {load_off, 3'b000});
                data_valid_reg <= 1'b1;
                if (!load_mmio) valid_bits_reg[load_idx] <= 1'b1;
            end
        end
    end

    assign dcache2core_data       = data_reg;
    assign dcache2core_data_valid = data_valid_reg;

endmodule

// File: tb/tb_dcache_responder.sv
// Randomized bench for dcache_responder against a byte-level memory model.
module tb_dcache_responder;
    import dcache_responder_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        core2dcache_req = 1'b0;
    logic [31:0] core2dcache_addr = '0;
    logic [63:0] core2dcache_data = '0;
    logic        core2dcache_data_we = 1'b0;
    mem_size_t   core2dcache_data_size = MEM_BYTE;
    logic        dcache2core_ready;
    logic [63:0] dcache2core_data;
    logic        dcache2core_data_valid;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    mem_size_t   mem_req_size;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;

    always #5 clock = ~clock;

    dcache_responder dut (
        .clock                  (clock),
        .reset                  (reset),
        .core2dcache_req        (core2dcache_req),
        .core2dcache_addr       (core2dcache_addr),
        .core2dcache_data       (core2dcache_data),
        .core2dcache_data_we    (core2dcache_data_we),
        .core2dcache_data_size  (core2dcache_data_size),
        .dcache2core_ready      (dcache2core_ready),
        .dcache2core_data       (dcache2core_data),
        .dcache2core_data_valid (dcache2core_data_valid),
        .mem_req_valid          (mem_req_valid),
        .mem_req_ready          (mem_req_ready),
        .mem_req_we             (mem_req_we),
        .mem_req_addr           (mem_req_addr),
        .mem_req_wdata          (mem_req_wdata),
        .mem_req_size           (mem_req_size),
        .mem_resp_valid         (mem_resp_valid),
        .mem_resp_data          (mem_resp_data)
    );

    typedef struct {
        logic [31:0] a;
        logic [63:0] d;
        mem_size_t   s;
    } store_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          refill_cnt = 0;
    int          valid_cnt = 0;
    bit          hold_ready = 1'b0;
    int          resp_fixed = -1;
    bit          resp_pending = 1'b0;
    int          resp_cnt = 0;
    logic [31:0] resp_addr;
    logic [31:0] last_refill_addr = '0;
    logic [7:0]  core_mem [logic [31:0]];
    logic [7:0]  ext_mem [logic [31:0]];
    logic [31:0] resident [int];
    store_t      exp_st [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return 8'(a * 29 + 91);
    endfunction

    function automatic logic [7:0] rd_core(input logic [31:0] a);
        return core_mem.exists(a) ? core_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] rd_ext(input logic [31:0] a);
        return ext_mem.exists(a) ? ext_mem[a] : init_byte(a);
    endfunction

    // Core view: bytes from addr to the end of its 8-byte line, placed at bit 0.
    function automatic logic [63:0] expect_load(input logic [31:0] a);
        logic [63:0] r = '0;
        int off = int'(a[2:0]);
        for (int k = 0; k < 8 - off; k++) r[8*k +: 8] = rd_core(a + 32'(k));
        return r;
    endfunction

    function automatic logic [63:0] ext_line(input logic [31:0] la);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = rd_ext(la + 32'(k));
        return r;
    endfunction

    // Memory side: random ready, store drains checked in order, delayed refill data.
    initial begin
        store_t e;
        forever begin
            @(negedge clock);
            mem_resp_valid = 1'b0;
            if (resp_pending) begin
                if (resp_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = ext_line(resp_addr);
                    resp_pending   = 1'b0;
                end else begin
                    resp_cnt--;
                end
            end
            if (dcache2core_data_valid) valid_cnt++;
            mem_req_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_we) begin
                    if (exp_st.size() == 0) begin
                        check("unexpected_drain", 64'(mem_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_st.pop_front();
                        check("drain_addr", 64'(mem_req_addr), 64'(e.a));
                        check("drain_data", mem_req_wdata, e.d);
                        check("drain_size", 64'(mem_req_size), 64'(e.s));
                        for (int k = 0; k < (1 << int'(e.s)); k++) ext_mem[e.a + 32'(k)] = e.d[8*k +: 8];
                    end
                end else begin
                    check("refill_size", 64'(mem_req_size), 64'(MEM_DWORD));
                    check("refill_align", 64'(mem_req_addr[2:0]), 64'd0);
                    check("drain_before_refill", 64'(exp_st.size()), 64'd0);
                    refill_cnt++;
                    last_refill_addr = mem_req_addr;
                    resp_addr    = mem_req_addr;
                    resp_pending = 1'b1;
                    resp_cnt     = (resp_fixed >= 0) ? resp_fixed : int'($urandom_range(1, 4));
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [63:0] d, input mem_size_t s);
        int g = 0;
        while (!dcache2core_ready && g < 500) begin
            @(negedge clock);
            g++;
        end
        check("ready_wait", 64'(dcache2core_ready), 64'd1);
        if (we) exp_st.push_back('{a: a, d: d, s: s});
        core2dcache_req       = 1'b1;
        core2dcache_addr      = a;
        core2dcache_data      = d;
        core2dcache_data_we   = we;
        core2dcache_data_size = s;
        @(negedge clock);
        core2dcache_req = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [63:0] d, input mem_size_t s);
        issue(1'b1, a, d, s);
        for (int k = 0; k < (1 << int'(s)); k++) core_mem[a + 32'(k)] = d[8*k +: 8];
        check("store_no_valid", 64'(dcache2core_data_valid), 64'd0);
        $display("store addr=%h size=%0d data=%h", a, int'(s), d);
    endtask

    task automatic do_load(input logic [31:0] a, input mem_size_t s,
                           output logic [63:0] d, output int lat, output int dref);
        logic [63:0] exp;
        bit hit_pred;
        int r0;
        int idx = int'(a[8:3]);
        exp = expect_load(a);
        hit_pred = resident.exists(idx) && (resident[idx] == (a & ~32'd7));
        r0 = refill_cnt;
        issue(1'b0, a, '0, s);
        lat = 1;
        while (!dcache2core_data_valid && lat < 400) begin
            @(negedge clock);
            lat++;
        end
        check("load_valid", 64'(dcache2core_data_valid), 64'd1);
        d = dcache2core_data;
        dref = refill_cnt - r0;
        check("load_data", d, exp);
        if (hit_pred) begin
            check("hit_latency", 64'(lat), 64'd1);
            check("hit_no_refill", 64'(dref), 64'd0);
        end else begin
            check("miss_one_refill", 64'(dref), 64'd1);
        end
        resident[idx] = a & ~32'd7;
        $display("load  addr=%h size=%0d data=%h lat=%0d refills=%0d", a, int'(s), d, lat, dref);
        @(negedge clock);
    endtask

    task automatic drain_wait();
        int g = 0;
        while (exp_st.size() != 0 && g < 2000) begin
            @(negedge clock);
            g++;
        end
        check("sb_drained", 64'(exp_st.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(dcache2core_ready), 64'd0);
        check({tag, "_data_valid"}, 64'(dcache2core_data_valid), 64'd0);
        check({tag, "_data"}, dcache2core_data, 64'd0);
        check({tag, "_mem_valid"}, 64'(mem_req_valid), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_req_addr), 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] line0;
        int lat, dref, g, v0, n;
        logic [31:0] a;
        mem_size_t s;

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", 64'(dcache2core_ready), 64'd1);

        line0 = 64'h1122334455667788;
        for (int k = 0; k < 8; k++) begin
            core_mem[32'h100 + 32'(k)] = line0[8*k +: 8];
            ext_mem[32'h100 + 32'(k)]  = line0[8*k +: 8];
        end

        do_load(32'h104, MEM_WORD, d, lat, dref);
        check("cold_load_data", d, 64'h0000_0000_1122_3344);
        check("cold_refill_count", 64'(dref), 64'd1);
        check("cold_refill_addr", 64'(last_refill_addr), 64'h100);
        do_load(32'h104, MEM_WORD, d, lat, dref);
        check("warm_load_data", d, 64'h0000_0000_1122_3344);
        check("warm_latency", 64'(lat), 64'd1);
        check("warm_no_refill", 64'(dref), 64'd0);

        do_store(32'h101, 64'hAB, MEM_BYTE);
        do_load(32'h100, MEM_DWORD, d, lat, dref);
        check("store_hit_merge", d, 64'h1122_3344_5566_AB88);
        check("store_hit_no_refill", 64'(dref), 64'd0);

        do_store(32'h200, 64'hDEAD_BEEF, MEM_WORD);
        do_load(32'h200, MEM_WORD, d, lat, dref);
        check("store_miss_reload", 64'(d[31:0]), 64'hDEAD_BEEF);
        check("store_miss_refill", 64'(dref), 64'd1);

        // Store buffer full with memory back-pressure.
        drain_wait();
        hold_ready = 1'b1;
        for (int i = 0; i < 4; i++) do_store(32'h400 + 32'(8 * i), {$urandom, $urandom}, MEM_DWORD);
        check("sb_full_ready", 64'(dcache2core_ready), 64'd0);
        check("sb_full_head", 64'(mem_req_addr), 64'h400);
        hold_ready = 1'b0;
        g = 0;
        while (!dcache2core_ready && g < 200) begin
            @(negedge clock);
            g++;
        end
        check("sb_ready_returns", 64'(dcache2core_ready), 64'd1);
        drain_wait();

        // Reset during REFILL_WAIT; the late response must be ignored.
        resp_fixed = 8;
        v0 = refill_cnt;
        issue(1'b0, 32'h300, '0, MEM_WORD);
        g = 0;
        while (refill_cnt == v0 && g < 200) begin
            @(negedge clock);
            g++;
        end
        check("midrefill_req_seen", 64'(refill_cnt - v0), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check_reset_outputs("midrefill");
        reset = 1'b0;
        resident.delete();
        v0 = valid_cnt;
        repeat (14) @(negedge clock);
        check("late_resp_ignored", 64'(valid_cnt - v0), 64'd0);
        resp_fixed = -1;
        do_load(32'h300, MEM_WORD, d, lat, dref);
        check("reload_after_reset", 64'(dref), 64'd1);

        // Random mix over a few conflicting lines.
        for (int i = 0; i < 300; i++) begin
            s = mem_size_t'($urandom_range(0, 3));
            n = 1 << int'(s);
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 3)
              | 32'($urandom_range(0, 8 / n - 1) * n);
            if ($urandom_range(0, 1) == 1) do_store(a, {$urandom, $urandom}, s);
            else                           do_load(a, s, d, lat, dref);
        end
        drain_wait();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Responder end of the core-to-dcache interface driven by the memory pipe: accepts load/store requests from the core and returns sign-agnostic, low-aligned load data with a valid pulse.
- Direct-mapped cache, write-through, no-write-allocate, 8-byte lines; a store buffer lets stores complete immediately from the core's view.
- Refills and store drains use a simple valid/ready memory port towards the L2/memory.

Parameters:
- NUM_LINES, 64, number of direct-mapped lines (power of 2); index = addr[3+log2(NUM_LINES)-1:3].
- SB_DEPTH, 4, store buffer entries (power of 2).

Ports:
- clock  input  1  clock
- reset  input  1  reset, synchronous, active-high
- core2dcache_req  input  1  one-cycle pulse, new request
- core2dcache_addr  input  32  byte address, aligned to size
- core2dcache_data  input  64  store data, low-aligned
- core2dcache_data_we  input  1  1=store, 0=load
- core2dcache_data_size  input  mem_size_t  BYTE/HALF/WORD/DWORD
- dcache2core_ready  output  1  may accept core2dcache_req this cycle
- dcache2core_data  output  64  load data, shifted to bit 0, upper bytes unmasked
- dcache2core_data_valid  output  1  one-cycle pulse, load complete
- mem_req_valid  output  1  memory request valid
- mem_req_ready  input  1  memory accepts request
- mem_req_we  output  1  1=store drain, 0=line refill
- mem_req_addr  output  32  refill: line address (addr[2:0]=0); store: byte address
- mem_req_wdata  output  64  store data, low-aligned
- mem_req_size  output  mem_size_t  store size; DWORD for refill
- mem_resp_valid  input  1  refill data valid
- mem_resp_data  input  64  refill line

Behaviour:
- Reset: all outputs 0; line valid bits cleared; store buffer emptied; FSM IDLE. Reset mid-refill abandons the refill; a late mem_resp_valid in IDLE is ignored.
- dcache2core_ready = (state==IDLE) & !sb_full. A req while ready=0 is a protocol violation (core guarantees it does not happen).
- FSM states: IDLE, DRAIN, REFILL_REQ, REFILL_WAIT.
- Load hit (IDLE): dcache2core_data = line >> (8*addr[2:0]), data_valid=1 the next cycle (latency 1). State stays IDLE.
- Load miss: if SB non-empty go DRAIN until empty, else REFILL_REQ. REFILL_REQ holds mem_req_valid until mem_req_ready (addr&~7, we=0). REFILL_WAIT waits for mem_resp_valid, writes the line/tag/valid, and returns the shifted data with data_valid the same cycle as the response write (registered, one cycle after mem_resp_valid). Then IDLE.
- Store (IDLE, ready=1): always enqueued into the SB. On a hit, the byte-enable merge into the line happens the same edge. On a miss, the line is untouched. data_valid is never asserted for stores.
- SB drain: head presented on the mem port whenever non-empty and state ∈ {IDLE, DRAIN}; pops on mem_req_valid & mem_req_ready. Refill requests never overlap drain (the port is mutually exclusive by state).
- Simultaneous enqueue and pop in the same cycle: count unchanged. Pointers wrap modulo SB_DEPTH.
- Byte enables: BYTE=1, HALF=3, WORD=0xF, DWORD=0xFF, shifted by addr[2:0]. Misaligned access: undefined data, no hang.

Optional Feature:
- DCACHE_MMIO_BYPASS_EN defined: addresses with addr[31:28]==4'hF are uncached.
  - Loads never hit; they drain the SB, issue a mem request with the exact address/size, return mem_resp_data unshifted, and do not allocate.
  - Stores are enqueued without a cache update.
- Undefined: the whole address space is cached.

Decomposition:
- Shared package: mem_size_t (already existing), byte-enable function, dcache FSM state enum, line/tag width localparams derived from NUM_LINES.
- One sub-module: dcache_store_buffer (FIFO with push/pop/full/empty/head entry).

Test Plan:
- Cold load: write mem 0x100=0x1122334455667788; load WORD 0x104 → mem refill req addr 0x100; data_valid with data[31:0]=0x11223344. Repeat the load → hit, valid 1 cycle after req, no mem request.
- Store hit: after the above, store BYTE 0xAB to 0x101 → mem_req we=1 addr 0x101 size BYTE; load DWORD 0x100 → 0x112233445566AB88 with no refill.
- Store miss then load same line: store WORD 0xDEADBEEF to 0x200, load WORD 0x200 → drain precedes refill on the mem port; returned 0xDEADBEEF.
- SB full: hold mem_req_ready=0, issue 4 stores → ready drops after the 4th; release ready → 4 drains in order, ready returns.
- Reset mid-refill: load miss, assert reset during REFILL_WAIT, then mem_resp_valid → no data_valid, all outputs 0, reload misses again.
- Bypass (macro on): load WORD 0xF0000010 twice → two mem requests addr 0xF0000010 size WORD, no allocation.
